// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - opcode, funct3 and halt constants for the RV32I load/store core
package tb_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/tb_mem_data.sv
// rtl/tb_mem_data.sv - byte-enabled data memory, async read, contents never cleared
module mem_data #(
  parameter int DATA_WORDS = 16,
  parameter int AW         = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] dataArray [DATA_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) dataArray[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = dataArray[i_addr];

endmodule

// File: rtl/tb.sv
// rtl/tb.sv - single-cycle RV32I load/store core with program and data memories
// Optional: TB_MISALIGN_TRAP_EN traps and suppresses misaligned halfword/word accesses.
module tb
  import tb_pkg::*;
#(
  parameter int PROG_WORDS = 16,
  parameter int DATA_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        done,
  output logic        error
);

  localparam int PAW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
  localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  if (1) begin : top_inst
    logic [31:0]    r_pc;
    logic [31:0]    r_regs [32];
    logic           r_error;

    logic [31:0]    w_instr;
    logic [6:0]     w_opc;
    logic [4:0]     w_rd;
    logic [4:0]     w_rs1;
    logic [4:0]     w_rs2;
    logic [2:0]     w_f3;
    logic [31:0]    w_imm_i;
    logic [31:0]    w_imm_s;
    logic [31:0]    w_imm_u;
    logic [31:0]    w_rs1v;
    logic [31:0]    w_rs2v;
    logic [31:0]    w_addr;
    logic [DAW-1:0] w_didx;
    logic [31:0]    w_rdata;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_data;
    logic           w_halt;
    logic           w_illegal;
    logic           w_misalign;
    logic           w_rd_we;
    logic [31:0]    w_rd_data;
    logic           w_mem_we;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_next_pc;

    if (1) begin : mem_prog_inst
      logic [31:0]    progArray [PROG_WORDS];
      logic           w_prog_we;
      logic [PAW-1:0] w_prog_widx;
      logic [31:0]    w_prog_wdata;
      logic [PAW-1:0] w_pidx;

      // In-system write port is tied off; contents are loaded by the environment.
      assign w_prog_we    = 1'b0;
      assign w_prog_widx  = '0;
      assign w_prog_wdata = '0;

      always_ff @(posedge clk) begin
        if (w_prog_we) progArray[w_prog_widx] <= w_prog_wdata;
      end

      assign w_pidx  = PAW'(r_pc[31:2] % 30'(PROG_WORDS));
      assign w_instr = progArray[w_pidx];
    end

    assign w_opc   = w_instr[6:0];
    assign w_rd    = w_instr[11:7];
    assign w_f3    = w_instr[14:12];
    assign w_rs1   = w_instr[19:15];
    assign w_rs2   = w_instr[24:20];
    assign w_imm_i = sext12(w_instr[31:20]);
    assign w_imm_s = sext12({w_instr[31:25], w_instr[11:7]});
    assign w_imm_u = {w_instr[31:12], 12'h000};
    assign w_rs1v  = r_regs[w_rs1];
    assign w_rs2v  = r_regs[w_rs2];
    assign w_halt  = (w_instr == HALT_WORD);

    assign w_addr = w_rs1v + ((w_opc == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_didx = DAW'(w_addr[31:2] % 30'(DATA_WORDS));

    // Stores are blocked while reset is low so a preloaded program cannot write during reset.
    mem_data #(
      .DATA_WORDS(DATA_WORDS),
      .AW        (DAW)
    ) mem_data_inst (
      .clk    (clk),
      .i_we   (w_mem_we & rst_n),
      .i_be   (w_be),
      .i_addr (w_didx),
      .i_wdata(w_wdata),
      .o_rdata(w_rdata)
    );

    always_comb begin
      w_byte      = w_rdata[{w_addr[1:0], 3'b000} +: 8];
      w_half      = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
      w_load_data = w_rdata;
      case (w_f3)
        F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
        F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
        F3_BU:   w_load_data = {24'h000000, w_byte};
        F3_HU:   w_load_data = {16'h0000, w_half};
        default: w_load_data = w_rdata;
      endcase
    end

    always_comb begin
      w_rd_we    = 1'b0;
      w_rd_data  = '0;
      w_mem_we   = 1'b0;
      w_be       = 4'b0000;
      w_wdata    = '0;
      w_illegal  = 1'b0;
      w_misalign = 1'b0;
      case (w_opc)
        OPC_LUI: begin
          w_rd_we   = 1'b1;
          w_rd_data = w_imm_u;
        end
        OPC_AUIPC: begin
          w_rd_we   = 1'b1;
          w_rd_data = r_pc + w_imm_u;
        end
        OPC_OPIMM: begin
          if (w_f3 == F3_ADDI) begin
            w_rd_we   = 1'b1;
            w_rd_data = w_rs1v + w_imm_i;
          end else begin
            w_illegal = 1'b1;
          end
        end
        OPC_LOAD: begin
          case (w_f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: begin
              w_rd_we   = 1'b1;
              w_rd_data = w_load_data;
            end
            default: w_illegal = 1'b1;
          endcase
        end
        OPC_STORE: begin
          case (w_f3)
            F3_B: begin
              w_mem_we = 1'b1;
              w_be     = 4'b0001 << w_addr[1:0];
              w_wdata  = {4{w_rs2v[7:0]}};
            end
            F3_H: begin
              w_mem_we = 1'b1;
              w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
              w_wdata  = {2{w_rs2v[15:0]}};
            end
            F3_W: begin
              w_mem_we = 1'b1;
              w_be     = 4'b1111;
              w_wdata  = w_rs2v;
            end
            default: w_illegal = 1'b1;
          endcase
        end
        default: w_illegal = !w_halt;
      endcase
`ifdef TB_MISALIGN_TRAP_EN
      // f3[1:0] encodes access size for both loads and stores: 01 half, 10 word.
      if ((w_opc == OPC_LOAD || w_opc == OPC_STORE) && !w_illegal) begin
        w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                     ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        if (w_misalign) begin
          w_rd_we  = 1'b0;
          w_mem_we = 1'b0;
        end
      end
`endif
    end

    assign w_next_pc = w_halt ? r_pc : r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pc    <= '0;
        r_error <= 1'b0;
        for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else begin
        r_pc <= w_next_pc;
        if (w_illegal || w_misalign) r_error <= 1'b1;
        if (w_rd_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_rd_data;
      end
    end

    assign pc    = r_pc;
    assign instr = w_instr;
    assign done  = w_halt;
    assign error = r_error;
  end

endmodule

// File: tb/tb_tb.sv
// tb/tb_tb.sv - self-checking bench for the tb load/store core with an ISA-level reference model
module tb_tb;
  import tb_pkg::*;

  localparam int PW = 16;
  localparam int DW = 16;
`ifdef TB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_prog [PW];
  logic [7:0]  m_mem  [DW*4];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc;
  logic        m_err;

  tb #(.PROG_WORDS(PW), .DATA_WORDS(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pc   (pc),
    .instr(instr),
    .done (done),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return int'(((a >> 2) % 32'(DW)) * 4) + int'(a[1:0]);
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {m_mem[w*4+3], m_mem[w*4+2], m_mem[w*4+1], m_mem[w*4]};
  endfunction

  task automatic m_wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) m_x[rd] = v;
  endtask

  // Architectural model: byte-addressed memory, accesses assembled byte by byte.
  task automatic model_step();
    logic [31:0] ins, a, v, immi, imms;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    int          sz;
    ins = m_prog[(m_pc >> 2) % 32'(PW)];
    if (ins == 32'h0) return;
    rd   = ins[11:7];
    rs1  = ins[19:15];
    rs2  = ins[24:20];
    f3   = ins[14:12];
    immi = 32'($signed(ins[31:20]));
    imms = 32'($signed({ins[31:25], ins[11:7]}));
    case (ins[6:0])
      7'b0110111: m_wr(rd, {ins[31:12], 12'h0});
      7'b0010111: m_wr(rd, m_pc + {ins[31:12], 12'h0});
      7'b0010011: if (f3 == 3'd0) m_wr(rd, m_x[rs1] + immi); else m_err = 1'b1;
      7'b0000011: begin
        if (f3 == 3'd3 || f3 > 3'd5) m_err = 1'b1;
        else begin
          sz = 1 << f3[1:0];
          a  = m_x[rs1] + immi;
          if (TRAP && (a & 32'(sz - 1)) != 0) m_err = 1'b1;
          else begin
            a = a & ~32'(sz - 1);
            v = 0;
            for (int k = 0; k < sz; k++) v = v | (32'(m_mem[bidx(a + 32'(k))]) << (8 * k));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            m_wr(rd, v);
          end
        end
      end
      7'b0100011: begin
        if (f3 > 3'd2) m_err = 1'b1;
        else begin
          sz = 1 << f3[1:0];
          a  = m_x[rs1] + imms;
          if (TRAP && (a & 32'(sz - 1)) != 0) m_err = 1'b1;
          else begin
            a = a & ~32'(sz - 1);
            for (int k = 0; k < sz; k++) m_mem[bidx(a + 32'(k))] = 8'(m_x[rs2] >> (8 * k));
          end
        end
      end
      default: m_err = 1'b1;
    endcase
    m_pc = m_pc + 32'd4;
  endtask

  task automatic load_prog();
    for (int i = 0; i < PW; i++) dut.top_inst.mem_prog_inst.progArray[i] = m_prog[i];
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    dut.top_inst.mem_data_inst.dataArray[i] = v;
    for (int k = 0; k < 4; k++) m_mem[i*4+k] = v[8*k +: 8];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #100;
    m_pc  = 32'h0;
    m_err = 1'b0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_load_prog();
    for (int i = 0; i < PW; i++) m_prog[i] = 32'h0;
    m_prog[0] = enc_i(12'd0, 5'd0, F3_W,  5'd1, OPC_LOAD);
    m_prog[1] = enc_i(12'd0, 5'd0, F3_B,  5'd2, OPC_LOAD);
    m_prog[2] = enc_i(12'd0, 5'd0, F3_BU, 5'd3, OPC_LOAD);
    m_prog[3] = enc_i(12'd2, 5'd0, F3_H,  5'd4, OPC_LOAD);
    m_prog[4] = enc_i(12'd2, 5'd0, F3_HU, 5'd5, OPC_LOAD);
  endtask

  task automatic test_reset();
    build_load_prog();
    set_word(0, 32'h8070F0FF);
    load_prog();
    rst_n = 1'b0;
    #100;
    n_vec++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b exp 0", error); end
    n_vec++; if (dut.top_inst.mem_data_inst.dataArray[0] !== 32'h8070F0FF) begin
      n_bad++; $display("FAIL reset_data0 got %h exp %h", dut.top_inst.mem_data_inst.dataArray[0], 32'h8070F0FF);
    end
    n_vec++; if (instr !== m_prog[0]) begin n_bad++; $display("FAIL reset_instr got %h exp %h", instr, m_prog[0]); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [31:0] e [1:5];
    e[1] = 32'h8070F0FF; e[2] = 32'hFFFFFFFF; e[3] = 32'h000000FF;
    e[4] = 32'hFFFF8070; e[5] = 32'h00008070;
    build_load_prog();
    set_word(0, 32'h8070F0FF);
    load_prog();
    do_reset();
    run(7);
    for (int r = 1; r <= 5; r++) begin
      n_vec++; if (dut.top_inst.r_regs[r] !== e[r]) begin
        n_bad++; $display("FAIL load_x%0d got %h exp %h", r, dut.top_inst.r_regs[r], e[r]);
      end
    end
    n_vec++; if (pc !== 32'd20) begin n_bad++; $display("FAIL load_pc got %h exp %h", pc, 32'd20); end
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL load_done got %b exp 1", done); end
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL load_error got %b exp 0", error); end
  endtask

  task automatic test_store();
    for (int i = 0; i < PW; i++) m_prog[i] = 32'h0;
    m_prog[0] = enc_u(20'h12345, 5'd6, OPC_LUI);
    m_prog[1] = enc_i(12'h678, 5'd6, F3_ADDI, 5'd6, OPC_OPIMM);
    m_prog[2] = enc_s(12'd1, 5'd6, 5'd0, F3_B);
    m_prog[3] = enc_s(12'd2, 5'd6, 5'd0, F3_H);
    m_prog[4] = enc_s(12'd4, 5'd6, 5'd0, F3_W);
    set_word(0, 32'h8070F0FF);
    set_word(1, 32'h0);
    load_prog();
    do_reset();
    run(2);
    n_vec++; if (dut.top_inst.r_regs[6] !== 32'h12345678) begin
      n_bad++; $display("FAIL store_x6 got %h exp %h", dut.top_inst.r_regs[6], 32'h12345678);
    end
    run(1);
    n_vec++; if (dut.top_inst.mem_data_inst.dataArray[0] !== 32'h807078FF) begin
      n_bad++; $display("FAIL store_sb got %h exp %h", dut.top_inst.mem_data_inst.dataArray[0], 32'h807078FF);
    end
    run(1);
    n_vec++; if (dut.top_inst.mem_data_inst.dataArray[0] !== 32'h567878FF) begin
      n_bad++; $display("FAIL store_sh got %h exp %h", dut.top_inst.mem_data_inst.dataArray[0], 32'h567878FF);
    end
    run(1);
    n_vec++; if (dut.top_inst.mem_data_inst.dataArray[1] !== 32'h12345678) begin
      n_bad++; $display("FAIL store_sw got %h exp %h", dut.top_inst.mem_data_inst.dataArray[1], 32'h12345678);
    end
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL store_error got %b exp 0", error); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e [1:5];
    int cyc;
    e[1] = 32'h567878FF; e[2] = 32'hFFFFFFFF; e[3] = 32'h000000FF;
    e[4] = 32'h00005678; e[5] = 32'h00005678;
    build_load_prog();
    load_prog();
    do_reset();
    cyc = 0;
    while (pc !== 32'd8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++; if (pc !== 32'd8) begin n_bad++; $display("FAIL midrun_reach_pc8 got %h exp %h", pc, 32'd8); end
    n_vec++; if (dut.top_inst.r_regs[1] !== 32'h567878FF) begin
      n_bad++; $display("FAIL midrun_x1_before got %h exp %h", dut.top_inst.r_regs[1], 32'h567878FF);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (pc !== 32'h0) begin n_bad++; $display("FAIL midrun_pc_async got %h exp 0", pc); end
    n_vec++; if (dut.top_inst.r_regs[1] !== 32'h0) begin
      n_bad++; $display("FAIL midrun_x1_cleared got %h exp 0", dut.top_inst.r_regs[1]);
    end
    do_reset();
    run(7);
    for (int r = 1; r <= 5; r++) begin
      n_vec++; if (dut.top_inst.r_regs[r] !== e[r]) begin
        n_bad++; $display("FAIL midrun_x%0d got %h exp %h", r, dut.top_inst.r_regs[r], e[r]);
      end
    end
    n_vec++; if (dut.top_inst.mem_data_inst.dataArray[1] !== 32'h12345678) begin
      n_bad++; $display("FAIL midrun_word1 got %h exp %h", dut.top_inst.mem_data_inst.dataArray[1], 32'h12345678);
    end
  endtask

  task automatic test_halt();
    logic [11:0] imm [4];
    logic [31:0] ex;
    for (int i = 0; i < PW; i++) m_prog[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      imm[i] = 12'($urandom);
      m_prog[i] = enc_i(imm[i], 5'd0, F3_ADDI, 5'(i + 1), OPC_OPIMM);
    end
    load_prog();
    do_reset();
    run(4);
    n_vec++; if (pc !== 32'd16) begin n_bad++; $display("FAIL halt_pc got %h exp %h", pc, 32'd16); end
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL halt_done got %b exp 1", done); end
    for (int i = 0; i < 4; i++) begin
      ex = 32'($signed(imm[i]));
      n_vec++; if (dut.top_inst.r_regs[i+1] !== ex) begin
        n_bad++; $display("FAIL halt_addi_x%0d got %h exp %h", i + 1, dut.top_inst.r_regs[i+1], ex);
      end
    end
    for (int c = 0; c < 3; c++) begin
      run(1);
      n_vec++; if (pc !== 32'd16 || done !== 1'b1) begin
        n_bad++; $display("FAIL halt_hold%0d got pc=%h done=%b exp pc=%h done=1", c, pc, done, 32'd16);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ex7;
    logic        exerr;
`ifdef TB_MISALIGN_TRAP_EN
    ex7 = 32'h00000055; exerr = 1'b1;
`else
    ex7 = 32'h8070F0FF; exerr = 1'b0;
`endif
    for (int i = 0; i < PW; i++) m_prog[i] = 32'h0;
    m_prog[0] = enc_i(12'h055, 5'd0, F3_ADDI, 5'd7, OPC_OPIMM);
    m_prog[1] = enc_i(12'd2, 5'd0, F3_W, 5'd7, OPC_LOAD);
    set_word(0, 32'h8070F0FF);
    load_prog();
    do_reset();
    run(3);
    n_vec++; if (dut.top_inst.r_regs[7] !== ex7) begin
      n_bad++; $display("FAIL misalign_x7 got %h exp %h", dut.top_inst.r_regs[7], ex7);
    end
    n_vec++; if (error !== exerr) begin n_bad++; $display("FAIL misalign_error got %b exp %b", error, exerr); end
    n_vec++; if (pc !== 32'd8) begin n_bad++; $display("FAIL misalign_pc got %h exp %h", pc, 32'd8); end
    do_reset();
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL misalign_error_cleared got %b exp 0", error); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r;
    rd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
    rs1 = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
    rs2 = 5'($urandom_range(0, 7));
    r   = $urandom;
    case ($urandom_range(0, 9))
      0: return enc_u(r[19:0], rd, OPC_LUI);
      1: return enc_u(r[19:0], rd, OPC_AUIPC);
      2, 3: begin
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : F3_ADDI;
        return enc_i(r[11:0], rs1, f3, rd, OPC_OPIMM);
      end
      4, 5, 6: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 > 3'd5) f3 = F3_W;
        return enc_i(r[11:0], rs1, f3, rd, OPC_LOAD);
      end
      7, 8: return enc_s(r[11:0], rs2, rs1, 3'($urandom_range(0, 3)));
      default: return (r == 32'h0) ? 32'h1 : r;
    endcase
  endfunction

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      for (int w = 0; w < DW; w++) set_word(w, $urandom);
      for (int i = 0; i < PW - 1; i++) m_prog[i] = rand_instr();
      m_prog[PW-1] = HALT_WORD;
      load_prog();
      do_reset();
      n_vec++; if (pc !== 32'h0 || error !== 1'b0) begin
        n_bad++; $display("FAIL rand%0d_reset got pc=%h err=%b exp pc=0 err=0", it, pc, error);
      end
      for (int c = 0; c < PW + 2; c++) begin
        @(negedge clk);
        model_step();
        n_vec++; if (pc !== m_pc) begin
          n_bad++; $display("FAIL rand%0d_pc_c%0d got %h exp %h", it, c, pc, m_pc);
        end
      end
      n_vec++; if (error !== m_err) begin n_bad++; $display("FAIL rand%0d_error got %b exp %b", it, error, m_err); end
      for (int r = 1; r < 32; r++) begin
        n_vec++; if (dut.top_inst.r_regs[r] !== m_x[r]) begin
          n_bad++; $display("FAIL rand%0d_x%0d got %h exp %h", it, r, dut.top_inst.r_regs[r], m_x[r]);
        end
      end
      for (int w = 0; w < DW; w++) begin
        n_vec++; if (dut.top_inst.mem_data_inst.dataArray[w] !== m_word(w)) begin
          n_bad++; $display("FAIL rand%0d_mem%0d got %h exp %h", it, w, dut.top_inst.mem_data_inst.dataArray[w], m_word(w));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_reset_midrun();
    test_halt();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
